bpf16_requant_decim: RTL and testbench

Output stage placed directly downstream of the bpf16 FIR core. It consumes the core's wide signed result stream over ready/valid and keeps one sample in every DECIM. Each kept sample is rounded, arithmetic-shifted and saturated to OUT_W bits, then buffered in a 2-entry output FIFO toward the sink. Saturation events are reported through a sticky flag and a counter.

---
 rtl/bpf16_requant_decim.sv | 158 +++++++++++++++
 tb/tb_bpf16_requant_decim.sv | 340 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bpf16_requant_decim.sv
// bpf16_requant_decim: decimating round / shift / saturate stage behind the bpf16 FIR core.
// Kept samples are buffered in a 2-entry output FIFO; saturations feed a sticky flag and counter.
module bpf16_requant_decim #(
  parameter int IN_W  = 32,
  parameter int OUT_W = 16,
  parameter int SHIFT = 15,
  parameter int DECIM = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic [IN_W-1:0]  s_data,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [OUT_W-1:0] m_data,
  input  logic             sat_clr,
  output logic             sat_sticky,
  output logic [15:0]      sat_count
);

  localparam int PH_W   = (DECIM > 1) ? $clog2(DECIM) : 1;
  localparam int RND_SH = (SHIFT > 0) ? SHIFT - 1 : 0;

  localparam logic [PH_W-1:0]       PH_LAST = PH_W'(DECIM - 1);
  localparam logic [PH_W-1:0]       PH_ZERO = {PH_W{1'b0}};
  localparam logic signed [IN_W:0]  RND     = (SHIFT > 0) ? ({{IN_W{1'b0}}, 1'b1} << RND_SH)
                                                          : {(IN_W+1){1'b0}};
  localparam logic signed [IN_W:0]  MAX_W   = {{(IN_W-OUT_W+2){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic signed [IN_W:0]  MIN_W   = {{(IN_W-OUT_W+2){1'b1}}, {(OUT_W-1){1'b0}}};
  localparam logic [OUT_W-1:0]      MAX_Q   = {1'b0, {(OUT_W-1){1'b1}}};
  localparam logic [OUT_W-1:0]      MIN_Q   = {1'b1, {(OUT_W-1){1'b0}}};
  localparam logic [15:0]           CNT_MAX = 16'hFFFF;

  // Returns {saturated, value}: round half-up, arithmetic shift, then clamp to OUT_W.
  function automatic logic [OUT_W:0] requant(input logic [IN_W-1:0] d);
    logic signed [IN_W:0] ext;
    logic signed [IN_W:0] shf;
    ext = signed'({d[IN_W-1], d}) + RND;
    shf = ext >>> SHIFT;
    if (shf > MAX_W) begin
      requant = {1'b1, MAX_Q};
    end else if (shf < MIN_W) begin
      requant = {1'b1, MIN_Q};
    end else begin
      requant = {1'b0, shf[OUT_W-1:0]};
    end
  endfunction

  logic [PH_W-1:0]  phase_r;
  logic [PH_W-1:0]  phase_nxt_s;
  logic [1:0]       count_r;
  logic [1:0]       count_nxt_s;
  logic [OUT_W-1:0] head_r;
  logic [OUT_W-1:0] tail_r;
  logic [OUT_W-1:0] head_nxt_s;
  logic [OUT_W-1:0] tail_nxt_s;
  logic             s_ready_r;
  logic             m_valid_r;
  logic             sat_sticky_r;
  logic [15:0]      sat_count_r;
  logic             accept_s;
  logic             push_s;
  logic             pop_s;
  logic             sat_s;
  logic [OUT_W-1:0] q_s;

  assign s_ready    = s_ready_r;
  assign m_valid    = m_valid_r;
  assign m_data     = head_r;
  assign sat_sticky = sat_sticky_r;
  assign sat_count  = sat_count_r;

  // Requantize the incoming sample and decode the handshakes.
  always_comb begin
    {sat_s, q_s} = requant(s_data);
    accept_s     = s_valid & s_ready_r;
    push_s       = accept_s & (phase_r == PH_ZERO);
    pop_s        = m_valid_r & m_ready;
  end

  // Next-state for decimation phase and the head/tail FIFO; head_r always drives m_data.
  always_comb begin
    phase_nxt_s = phase_r;
    count_nxt_s = count_r;
    head_nxt_s  = head_r;
    tail_nxt_s  = tail_r;
    if (accept_s) begin
      phase_nxt_s = (phase_r == PH_LAST) ? PH_ZERO : phase_r + {{(PH_W-1){1'b0}}, 1'b1};
    end else begin
      phase_nxt_s = phase_r;
    end
    case ({push_s, pop_s})
      2'b10: begin
        count_nxt_s = count_r + 2'd1;
        if (count_r == 2'd0) begin
          head_nxt_s = q_s;
        end else begin
          tail_nxt_s = q_s;
        end
      end
      2'b01: begin
        count_nxt_s = count_r - 2'd1;
        head_nxt_s  = tail_r;
      end
      // Push needs count<2 and pop needs count>0, so exactly one entry is held here.
      2'b11: begin
        head_nxt_s = q_s;
      end
      default: begin
        count_nxt_s = count_r;
      end
    endcase
  end

  // Datapath, FIFO and handshake registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      phase_r   <= PH_ZERO;
      count_r   <= 2'd0;
      head_r    <= {OUT_W{1'b0}};
      tail_r    <= {OUT_W{1'b0}};
      s_ready_r <= 1'b1;
      m_valid_r <= 1'b0;
    end else begin
      phase_r   <= phase_nxt_s;
      count_r   <= count_nxt_s;
      head_r    <= head_nxt_s;
      tail_r    <= tail_nxt_s;
      s_ready_r <= (count_nxt_s != 2'd2);
      m_valid_r <= (count_nxt_s != 2'd0);
    end
  end

  // Saturation statistics; a saturated push wins over a same-cycle clear.
  always_ff @(posedge clk) begin
    if (rst) begin
      sat_sticky_r <= 1'b0;
      sat_count_r  <= 16'h0000;
    end else if (push_s && sat_s) begin
      sat_sticky_r <= 1'b1;
      if (sat_clr) begin
        sat_count_r <= 16'h0001;
      end else if (sat_count_r != CNT_MAX) begin
        sat_count_r <= sat_count_r + 16'h0001;
      end else begin
        sat_count_r <= sat_count_r;
      end
    end else if (sat_clr) begin
      sat_sticky_r <= 1'b0;
      sat_count_r  <= 16'h0000;
    end else begin
      sat_sticky_r <= sat_sticky_r;
      sat_count_r  <= sat_count_r;
    end
  end

endmodule

// File: tb/tb_bpf16_requant_decim.sv
// Self-checking bench for bpf16_requant_decim: a DECIM=1 and a DECIM=4 instance share clock and reset,
// each with an expected-output queue filled on acceptance and drained by a negedge monitor.
module tb_bpf16_requant_decim;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        s_valid1, s_ready1, m_valid1, m_ready1, sat_clr1, sat_sticky1;
  logic [31:0] s_data1;
  logic [15:0] m_data1, sat_count1;
  logic        s_valid4, s_ready4, m_valid4, m_ready4, sat_clr4, sat_sticky4;
  logic [31:0] s_data4;
  logic [15:0] m_data4, sat_count4;

  bpf16_requant_decim #(.IN_W(32), .OUT_W(16), .SHIFT(15), .DECIM(1)) dut1 (
    .clk(clk), .rst(rst), .s_valid(s_valid1), .s_ready(s_ready1), .s_data(s_data1),
    .m_valid(m_valid1), .m_ready(m_ready1), .m_data(m_data1),
    .sat_clr(sat_clr1), .sat_sticky(sat_sticky1), .sat_count(sat_count1));

  bpf16_requant_decim #(.IN_W(32), .OUT_W(16), .SHIFT(15), .DECIM(4)) dut4 (
    .clk(clk), .rst(rst), .s_valid(s_valid4), .s_ready(s_ready4), .s_data(s_data4),
    .m_valid(m_valid4), .m_ready(m_ready4), .m_data(m_data4),
    .sat_clr(sat_clr4), .sat_sticky(sat_sticky4), .sat_count(sat_count4));

  typedef struct {
    logic [15:0] d;
    int          due;
  } exp_t;

  exp_t        q1[$];
  exp_t        q4[$];
  exp_t        e1, e4;
  int          errors = 0;
  int          checks = 0;
  int          cyc = 0;
  int          ph4 = 0;
  int          out4 = 0;
  bit          lat1 = 1'b0;
  bit          lat4 = 1'b0;
  bit          rnd4 = 1'b0;
  bit          stall4 = 1'b0;
  logic [15:0] hold4 = 16'h0000;

  always @(posedge clk) cyc <= cyc + 1;

  // Reference requantizer: round half-up at bit 14, shift by 15, clamp to int16.
  function automatic logic [15:0] model(input logic [31:0] d);
    longint v;
    v = longint'(signed'(d));
    v = v + 64'sd16384;
    v = v >>> 15;
    if (v > 64'sd32767) v = 64'sd32767;
    else if (v < -64'sd32768) v = -64'sd32768;
    return v[15:0];
  endfunction

  always @(negedge clk) begin
    if (rst) begin
      q1.delete();
    end else if (m_valid1 && m_ready1) begin
      checks++;
      if (q1.size() == 0) begin
        errors++;
        $display("FAIL d1_unexpected_output got=%h required=none", m_data1);
      end else begin
        e1 = q1.pop_front();
        if (m_data1 !== e1.d) begin
          errors++;
          $display("FAIL d1_data got=%h required=%h", m_data1, e1.d);
        end
        if (lat1) begin
          checks++;
          if (cyc != e1.due) begin
            errors++;
            $display("FAIL d1_latency got_cycle=%0d required_cycle=%0d", cyc, e1.due);
          end
        end
      end
    end
  end

  always @(negedge clk) begin
    if (rst) begin
      q4.delete();
      stall4 = 1'b0;
    end else begin
      if (stall4) begin
        checks++;
        if (m_data4 !== hold4) begin
          errors++;
          $display("FAIL d4_hold got=%h required=%h", m_data4, hold4);
        end
      end
      if (m_valid4 && m_ready4) begin
        checks++;
        out4++;
        if (q4.size() == 0) begin
          errors++;
          $display("FAIL d4_unexpected_output got=%h required=none", m_data4);
        end else begin
          e4 = q4.pop_front();
          if (m_data4 !== e4.d) begin
            errors++;
            $display("FAIL d4_data got=%h required=%h", m_data4, e4.d);
          end
          if (lat4) begin
            checks++;
            if (cyc != e4.due) begin
              errors++;
              $display("FAIL d4_latency got_cycle=%0d required_cycle=%0d", cyc, e4.due);
            end
          end
        end
      end
      stall4 = m_valid4 && !m_ready4;
      hold4  = m_data4;
    end
  end

  task automatic drive1(input logic [31:0] d, input logic [15:0] e);
    bit acc = 1'b0;
    s_valid1 = 1'b1;
    s_data1  = d;
    for (int t = 0; t < 50 && !acc; t++) begin
      @(negedge clk);
      if (s_ready1) begin
        acc = 1'b1;
        q1.push_back('{d: e, due: cyc + 1});
      end
      @(posedge clk); #1;
    end
    checks++;
    if (!acc) begin
      errors++;
      $display("FAIL d1_accept_timeout got=not_accepted required=accepted data=%h", d);
    end
  endtask

  task automatic drive4(input logic [31:0] d, input logic [15:0] e);
    bit acc = 1'b0;
    s_valid4 = 1'b1;
    s_data4  = d;
    for (int t = 0; t < 50 && !acc; t++) begin
      if (rnd4) m_ready4 = 1'($urandom_range(0, 1));
      @(negedge clk);
      if (s_ready4) begin
        acc = 1'b1;
        if (ph4 == 0) q4.push_back('{d: e, due: cyc + 1});
        ph4 = (ph4 + 1) % 4;
      end
      @(posedge clk); #1;
    end
    checks++;
    if (!acc) begin
      errors++;
      $display("FAIL d4_accept_timeout got=not_accepted required=accepted data=%h", d);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle(3);
    rst = 1'b0;
    ph4 = 0;
    @(negedge clk);
    checks += 8;
    if (m_valid1 !== 1'b0)     begin errors++; $display("FAIL rst_m_valid1 got=%b required=0", m_valid1); end
    if (m_data1 !== 16'h0000)  begin errors++; $display("FAIL rst_m_data1 got=%h required=0000", m_data1); end
    if (s_ready1 !== 1'b1)     begin errors++; $display("FAIL rst_s_ready1 got=%b required=1", s_ready1); end
    if (sat_sticky1 !== 1'b0)  begin errors++; $display("FAIL rst_sticky1 got=%b required=0", sat_sticky1); end
    if (sat_count1 !== 16'h0)  begin errors++; $display("FAIL rst_count1 got=%h required=0000", sat_count1); end
    if (m_valid4 !== 1'b0)     begin errors++; $display("FAIL rst_m_valid4 got=%b required=0", m_valid4); end
    if (m_data4 !== 16'h0000)  begin errors++; $display("FAIL rst_m_data4 got=%h required=0000", m_data4); end
    if (s_ready4 !== 1'b1)     begin errors++; $display("FAIL rst_s_ready4 got=%b required=1", s_ready4); end
    @(posedge clk); #1;
  endtask

  task automatic test_rounding();
    m_ready1 = 1'b1;
    lat1     = 1'b1;
    drive1(32'h0000_4000, 16'h0001);
    drive1(32'h0000_3FFF, 16'h0000);
    drive1(32'hFFFF_C000, 16'h0000);
    drive1(32'hFFFF_8000, 16'hFFFF);
    s_valid1 = 1'b0;
    idle(3);
    checks += 3;
    if (sat_count1 !== 16'h0) begin errors++; $display("FAIL round_sat_count got=%h required=0000", sat_count1); end
    if (sat_sticky1 !== 1'b0) begin errors++; $display("FAIL round_sticky got=%b required=0", sat_sticky1); end
    if (q1.size() != 0)       begin errors++; $display("FAIL round_missing got=%0d required=0", q1.size()); end
  endtask

  task automatic test_saturation();
    drive1(32'h4000_0000, 16'h7FFF);
    drive1(32'h8000_0000, 16'h8000);
    s_valid1 = 1'b0;
    idle(1);
    checks += 2;
    if (sat_count1 !== 16'd2) begin errors++; $display("FAIL sat_count2 got=%h required=0002", sat_count1); end
    if (sat_sticky1 !== 1'b1) begin errors++; $display("FAIL sat_sticky got=%b required=1", sat_sticky1); end
    sat_clr1 = 1'b1;
    drive1(32'h8000_0000, 16'h8000);
    sat_clr1 = 1'b0;
    s_valid1 = 1'b0;
    checks += 2;
    if (sat_count1 !== 16'd1) begin errors++; $display("FAIL sat_clr_push_count got=%h required=0001", sat_count1); end
    if (sat_sticky1 !== 1'b1) begin errors++; $display("FAIL sat_clr_push_sticky got=%b required=1", sat_sticky1); end
    sat_clr1 = 1'b1;
    idle(1);
    sat_clr1 = 1'b0;
    checks += 2;
    if (sat_count1 !== 16'd0) begin errors++; $display("FAIL sat_clr_count got=%h required=0000", sat_count1); end
    if (sat_sticky1 !== 1'b0) begin errors++; $display("FAIL sat_clr_sticky got=%b required=0", sat_sticky1); end
    idle(2);
    checks++;
    if (q1.size() != 0) begin errors++; $display("FAIL sat_missing got=%0d required=0", q1.size()); end
  endtask

  task automatic test_decimation();
    int c0, o0;
    m_ready4 = 1'b1;
    lat4     = 1'b1;
    c0 = cyc;
    o0 = out4;
    for (int k = 0; k < 12; k++) drive4(32'(k) << 15, 16'(k));
    checks++;
    if (cyc - c0 != 12) begin errors++; $display("FAIL back_to_back_cycles got=%0d required=12", cyc - c0); end
    s_valid4 = 1'b0;
    idle(3);
    checks += 2;
    if (out4 - o0 != 3) begin errors++; $display("FAIL decim_outputs got=%0d required=3", out4 - o0); end
    if (q4.size() != 0) begin errors++; $display("FAIL decim_missing got=%0d required=0", q4.size()); end
  endtask

  task automatic test_backpressure();
    int          c0;
    logic [31:0] d;
    lat4     = 1'b0;
    m_ready4 = 1'b0;
    c0 = cyc;
    for (int k = 0; k < 5; k++) drive4(32'(k) << 15, 16'(k));
    checks++;
    if (cyc - c0 != 5) begin errors++; $display("FAIL bp_fill_cycles got=%0d required=5", cyc - c0); end
    s_data4 = 32'(5) << 15;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      checks += 3;
      if (s_ready4 !== 1'b0)    begin errors++; $display("FAIL bp_s_ready got=%b required=0", s_ready4); end
      if (m_valid4 !== 1'b1)    begin errors++; $display("FAIL bp_m_valid got=%b required=1", m_valid4); end
      if (m_data4 !== 16'h0000) begin errors++; $display("FAIL bp_head got=%h required=0000", m_data4); end
      @(posedge clk); #1;
    end
    m_ready4 = 1'b1;
    for (int k = 5; k < 20; k++) drive4(32'(k) << 15, 16'(k));
    rnd4 = 1'b1;
    for (int i = 0; i < 60; i++) begin
      if (i % 5 == 0) d = $urandom;
      else d = 32'($urandom_range(0, 32'h01FF_FFFF)) - 32'h0100_0000;
      drive4(d, model(d));
    end
    rnd4     = 1'b0;
    m_ready4 = 1'b1;
    s_valid4 = 1'b0;
    idle(4);
    checks++;
    if (q4.size() != 0) begin errors++; $display("FAIL bp_missing got=%0d required=0", q4.size()); end
  endtask

  task automatic test_reset_midstream();
    int o0;
    m_ready4 = 1'b0;
    lat4     = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (q4.size() < 2) drive4(32'(i) << 15, 16'(i));
    end
    s_valid4 = 1'b0;
    @(negedge clk);
    checks += 2;
    if (s_ready4 !== 1'b0) begin errors++; $display("FAIL mid_full_ready got=%b required=0", s_ready4); end
    if (m_valid4 !== 1'b1) begin errors++; $display("FAIL mid_full_valid got=%b required=1", m_valid4); end
    @(posedge clk); #1;
    rst = 1'b1;
    idle(1);
    rst = 1'b0;
    ph4 = 0;
    @(negedge clk);
    checks += 2;
    if (m_valid4 !== 1'b0) begin errors++; $display("FAIL mid_rst_valid got=%b required=0", m_valid4); end
    if (s_ready4 !== 1'b1) begin errors++; $display("FAIL mid_rst_ready got=%b required=1", s_ready4); end
    @(posedge clk); #1;
    m_ready4 = 1'b1;
    lat4     = 1'b1;
    o0 = out4;
    drive4(32'(7) << 15, 16'd7);
    drive4(32'(8) << 15, 16'd8);
    s_valid4 = 1'b0;
    idle(3);
    checks += 2;
    if (out4 - o0 != 1) begin errors++; $display("FAIL mid_restart_outputs got=%0d required=1", out4 - o0); end
    if (q4.size() != 0) begin errors++; $display("FAIL mid_restart_missing got=%0d required=0", q4.size()); end
  endtask

  task automatic test_sat_ceiling();
    m_ready1 = 1'b1;
    lat1     = 1'b1;
    for (int i = 0; i < 65535; i++) drive1(32'h7FFF_FFFF, 16'h7FFF);
    checks++;
    if (sat_count1 !== 16'hFFFF) begin errors++; $display("FAIL ceil_reach got=%h required=ffff", sat_count1); end
    drive1(32'h8000_0000, 16'h8000);
    drive1(32'h7FFF_FFFF, 16'h7FFF);
    s_valid1 = 1'b0;
    idle(3);
    checks += 3;
    if (sat_count1 !== 16'hFFFF) begin errors++; $display("FAIL ceil_hold got=%h required=ffff", sat_count1); end
    if (sat_sticky1 !== 1'b1)    begin errors++; $display("FAIL ceil_sticky got=%b required=1", sat_sticky1); end
    if (q1.size() != 0)          begin errors++; $display("FAIL ceil_missing got=%0d required=0", q1.size()); end
  endtask

  initial begin
    rst      = 1'b1;
    s_valid1 = 1'b0; s_data1 = 32'h0; m_ready1 = 1'b0; sat_clr1 = 1'b0;
    s_valid4 = 1'b0; s_data4 = 32'h0; m_ready4 = 1'b0; sat_clr4 = 1'b0;
    test_reset();
    test_rounding();
    test_saturation();
    test_decimation();
    test_backpressure();
    test_reset_midstream();
    test_sat_ceiling();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
